// File: rtl/parking_lot_occupancy.sv
// Parking lot gate decoder and occupancy counter.
// Two synchronised photo-sensor levels {a,b} are tracked by one FSM that
// recognises complete enter (outer->inner) and exit (inner->outer) sequences.
// Completed sequences drive one-cycle event pulses and a saturating count.
// Two-bit sensor jumps park the FSM in WAIT until both beams clear and set
// a sticky error flag, as does any attempt to overflow or underflow the count.
module parking_lot_occupancy #(
  parameter int CAPACITY = 3,
  localparam int CW = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a,
  input  logic          b,
  output logic          enter,
  output logic          exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EN1  = 3'd1;
  localparam logic [2:0] S_EN2  = 3'd2;
  localparam logic [2:0] S_EN3  = 3'd3;
  localparam logic [2:0] S_EX1  = 3'd4;
  localparam logic [2:0] S_EX2  = 3'd5;
  localparam logic [2:0] S_EX3  = 3'd6;
  localparam logic [2:0] S_WAIT = 3'd7;

  localparam logic [CW-1:0] CAP_VAL = CW'(CAPACITY);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] ab;
  logic       enter_ev;
  logic       exit_ev;
  logic       to_wait;
  logic       at_cap;
  logic       at_zero;

  assign ab      = {a, b};
  assign at_cap  = (count == CAP_VAL);
  assign at_zero = (count == '0);

  // Next-state decode; also flags completed sequences and illegal jumps.
  always_comb begin
    state_nxt = state;
    enter_ev  = 1'b0;
    exit_ev   = 1'b0;
    case (state)
      S_IDLE: begin
        case (ab)
          2'b10:   state_nxt = S_EN1;
          2'b01:   state_nxt = S_EX1;
          2'b11:   state_nxt = S_WAIT;
          default: state_nxt = S_IDLE;
        endcase
      end
      S_EN1: begin
        case (ab)
          2'b11:   state_nxt = S_EN2;
          2'b00:   state_nxt = S_IDLE;
          2'b01:   state_nxt = S_WAIT;
          default: state_nxt = S_EN1;
        endcase
      end
      S_EN2: begin
        case (ab)
          2'b01:   state_nxt = S_EN3;
          2'b10:   state_nxt = S_EN1;
          2'b00:   state_nxt = S_WAIT;
          default: state_nxt = S_EN2;
        endcase
      end
      S_EN3: begin
        case (ab)
          2'b11:   state_nxt = S_EN2;
          2'b00: begin
            state_nxt = S_IDLE;
            enter_ev  = 1'b1;
          end
          2'b10:   state_nxt = S_WAIT;
          default: state_nxt = S_EN3;
        endcase
      end
      S_EX1: begin
        case (ab)
          2'b11:   state_nxt = S_EX2;
          2'b00:   state_nxt = S_IDLE;
          2'b10:   state_nxt = S_WAIT;
          default: state_nxt = S_EX1;
        endcase
      end
      S_EX2: begin
        case (ab)
          2'b10:   state_nxt = S_EX3;
          2'b01:   state_nxt = S_EX1;
          2'b00:   state_nxt = S_WAIT;
          default: state_nxt = S_EX2;
        endcase
      end
      S_EX3: begin
        case (ab)
          2'b11:   state_nxt = S_EX2;
          2'b00: begin
            state_nxt = S_IDLE;
            exit_ev   = 1'b1;
          end
          2'b01:   state_nxt = S_WAIT;
          default: state_nxt = S_EX3;
        endcase
      end
      default: begin
        if (ab == 2'b00) state_nxt = S_IDLE;
        else             state_nxt = S_WAIT;
      end
    endcase
  end

  // Only entry into WAIT from another state counts as an illegal jump.
  assign to_wait = (state_nxt == S_WAIT) && (state != S_WAIT);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // One-cycle event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enter <= 1'b0;
      exit  <= 1'b0;
    end else begin
      enter <= enter_ev;
      exit  <= exit_ev;
    end
  end

  // Saturating occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enter_ev && !at_cap) begin
      count <= count + 1'b1;
    end else if (exit_ev && !at_zero) begin
      count <= count - 1'b1;
    end
  end

  // Sticky error: illegal jump, overflow or underflow attempt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (to_wait || (enter_ev && at_cap) || (exit_ev && at_zero)) begin
      err <= 1'b1;
    end
  end

  assign full  = at_cap;
  assign empty = at_zero;

endmodule
